// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared definitions for the multicycle MIPS control unit.
//   state_e   - controller state encoding (4 bits, 12 encoded values)
//   OP_*/FN_* - supported opcode and R-type funct codes
//   ALU_*     - ALUControl encodings; ALUOP_* - internal ALUOp encodings
//   ctrl_t    - per-state datapath control word (before reset gating)
package mips_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_e;

    // Opcodes (instruction[31:26])
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // R-type funct codes (instruction[5:0])
    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    // ALUControl encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Control word decoded from the current state
    typedef struct packed {
        logic       iord;
        logic       reg_dst;
        logic       memto_reg;
        logic       ir_write;
        logic       we3;
        logic       alu_src_a;
        logic       branch;
        logic       pc_write;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       mem_write;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    // True for the six opcodes the controller sequences
    function automatic logic op_supported(input logic [OP_W-1:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory signal bundle.
//   Op, Funct   - instruction fields from the instruction register
//   mem_ready   - memory completes the current access this cycle
//   IorD, RegDst, MemtoReg, IRWrite, WE3, ALUSrcA, Branch, PCWrite,
//   ALUSrcB, PCSrc, ALUControl - datapath controls
//   MemWrite    - memory write request
//   retire      - last cycle of a completed instruction
//   illegal     - unsupported Op/Funct seen in DECODE
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;

    logic [5:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;

    logic       IorD;
    logic       RegDst;
    logic       MemtoReg;
    logic       IRWrite;
    logic       WE3;
    logic       ALUSrcA;
    logic       Branch;
    logic       PCWrite;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;
    logic       MemWrite;
    logic       retire;
    logic       illegal;

    modport master (
        input  Op, Funct, mem_ready,
        output IorD, RegDst, MemtoReg, IRWrite, WE3, ALUSrcA, Branch, PCWrite,
               ALUSrcB, PCSrc, ALUControl, MemWrite, retire, illegal
    );

    modport slave (
        output Op, Funct, mem_ready,
        input  IorD, RegDst, MemtoReg, IRWrite, WE3, ALUSrcA, Branch, PCWrite,
               ALUSrcB, PCSrc, ALUControl, MemWrite, retire, illegal
    );

endinterface

// File: rtl/alu_dec.sv
// alu_dec: combinational ALU decoder.
//   ALUOp         in  2  00 add, 01 sub, 10 decode Funct
//   Funct         in  6  R-type funct field
//   ALUControl    out 3  ALU operation
//   funct_illegal out 1  Funct is not a supported R-type code (independent of ALUOp)
module alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALUControl,
    output logic       funct_illegal
);

    logic [2:0] funct_ctl_c;

    // Funct lookup; also flags unsupported codes so DECODE can reject them
    always_comb begin
        funct_ctl_c   = ALU_ADD;
        funct_illegal = 1'b0;
        case (Funct)
            FN_ADD:  funct_ctl_c = ALU_ADD;
            FN_SUB:  funct_ctl_c = ALU_SUB;
            FN_AND:  funct_ctl_c = ALU_AND;
            FN_OR:   funct_ctl_c = ALU_OR;
            FN_SLT:  funct_ctl_c = ALU_SLT;
            default: funct_illegal = 1'b1;
        endcase
    end

    // ALUOp selects a fixed operation or the Funct lookup; 11 is unused and adds
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB:   ALUControl = ALU_SUB;
            ALUOP_FUNCT: ALUControl = funct_ctl_c;
            default:     ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle MIPS datapath.
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high; forces FETCH and masks all enables
//   bus    multicycle_ctrl_if.master: Op/Funct/mem_ready in, datapath
//          controls, MemWrite, retire and illegal out
// Controls are decoded from the state register; the only input-dependent
// terms are the mem_ready handshake in FETCH/MEMWRITE and illegal in DECODE.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_t              ctrl_c;
    logic [1:0]         alu_op_c;
    logic [2:0]         alu_control_c;
    logic               funct_illegal_c;
    logic               decode_illegal_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ALUOp depends on state only, kept apart from the main decode so the
    // funct_illegal path back into DECODE stays acyclic
    always_comb begin
        alu_op_c = ALUOP_ADD;
        case (state_q)
            EXECUTE: alu_op_c = ALUOP_FUNCT;
            BRANCH:  alu_op_c = ALUOP_SUB;
            default: alu_op_c = ALUOP_ADD;
        endcase
    end

    alu_dec u_alu_dec (
        .ALUOp         (alu_op_c),
        .Funct         (bus.Funct),
        .ALUControl    (alu_control_c),
        .funct_illegal (funct_illegal_c)
    );

    assign decode_illegal_c = !op_supported(bus.Op) ||
                              ((bus.Op == OP_RTYPE) && funct_illegal_c);

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        ctrl_c  = '0;
        case (state_q)
            FETCH: begin
                ctrl_c.alu_src_b = 2'b01;
                ctrl_c.ir_write  = bus.mem_ready;
                ctrl_c.pc_write  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ctrl_c.alu_src_b = 2'b11;
                if (decode_illegal_c) begin
                    ctrl_c.illegal = 1'b1;
                    state_d        = FETCH;
                end else begin
                    case (bus.Op)
                        OP_LW, OP_SW: state_d = MEMADR;
                        OP_RTYPE:     state_d = EXECUTE;
                        OP_BEQ:       state_d = BRANCH;
                        OP_ADDI:      state_d = ADDIEXEC;
                        OP_J:         state_d = JUMP;
                        default:      state_d = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
                state_d          = (bus.Op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                ctrl_c.iord = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                ctrl_c.memto_reg = 1'b1;
                ctrl_c.we3       = 1'b1;
                ctrl_c.retire    = 1'b1;
                state_d          = FETCH;
            end
            MEMWRITE: begin
                // Request stays up across the stall; retire marks the accepting cycle
                ctrl_c.iord      = 1'b1;
                ctrl_c.mem_write = 1'b1;
                ctrl_c.retire    = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXECUTE: begin
                ctrl_c.alu_src_a = 1'b1;
                state_d          = ALUWB;
            end
            ALUWB: begin
                ctrl_c.reg_dst = 1'b1;
                ctrl_c.we3     = 1'b1;
                ctrl_c.retire  = 1'b1;
                state_d        = FETCH;
            end
            BRANCH: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.pc_src    = 2'b01;
                ctrl_c.branch    = 1'b1;
                ctrl_c.retire    = 1'b1;
                state_d          = FETCH;
            end
            ADDIEXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
                state_d          = ADDIWB;
            end
            ADDIWB: begin
                ctrl_c.we3    = 1'b1;
                ctrl_c.retire = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                ctrl_c.pc_src   = 2'b10;
                ctrl_c.pc_write = 1'b1;
                ctrl_c.retire   = 1'b1;
                state_d         = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Selects pass straight through; enables and pulses are masked by reset
    assign bus.IorD       = ctrl_c.iord;
    assign bus.RegDst     = ctrl_c.reg_dst;
    assign bus.MemtoReg   = ctrl_c.memto_reg;
    assign bus.ALUSrcA    = ctrl_c.alu_src_a;
    assign bus.ALUSrcB    = ctrl_c.alu_src_b;
    assign bus.PCSrc      = ctrl_c.pc_src;
    assign bus.ALUControl = alu_control_c;
    assign bus.IRWrite    = ctrl_c.ir_write  & ~reset;
    assign bus.PCWrite    = ctrl_c.pc_write  & ~reset;
    assign bus.WE3        = ctrl_c.we3       & ~reset;
    assign bus.MemWrite   = ctrl_c.mem_write & ~reset;
    assign bus.Branch     = ctrl_c.branch    & ~reset;
    assign bus.retire     = ctrl_c.retire    & ~reset;
    assign bus.illegal    = ctrl_c.illegal   & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl.
// The stimulus side expands each instruction into its sequence of phases,
// drives one cycle per phase (plus stall cycles), and queues the control
// word that phase must show. The monitor pops and compares every cycle.
module tb_multicycle_ctrl;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
        P_EXEC, P_ALUWB, P_BRANCH, P_ADDIEXEC, P_ADDIWB, P_JUMP, P_RESET
    } phase_e;

    typedef struct packed {
        logic       iord;
        logic       reg_dst;
        logic       memto_reg;
        logic       ir_write;
        logic       we3;
        logic       alu_src_a;
        logic       branch;
        logic       pc_write;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       mem_write;
        logic       retire;
        logic       illegal;
    } obs_t;

    typedef struct {
        obs_t   w;
        phase_e ph;
    } exp_t;

    logic clk;
    logic reset;
    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t expq[$];
    int   checks       = 0;
    int   errors       = 0;
    int   retire_seen  = 0;
    int   illegal_seen = 0;
    int   retire_exp   = 0;
    int   illegal_exp  = 0;

    // ---------------- reference model ----------------
    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        bit fn_ok;
        fn_ok = (fn == 6'd32) || (fn == 6'd34) || (fn == 6'd36) ||
                (fn == 6'd37) || (fn == 6'd42);
        case (op)
            6'd35, 6'd43, 6'd4, 6'd8, 6'd2: return 1'b1;
            6'd0:                           return fn_ok;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'd32:   return 3'b010;   // add
            6'd34:   return 3'b110;   // sub
            6'd36:   return 3'b000;   // and
            6'd37:   return 3'b001;   // or
            6'd42:   return 3'b111;   // slt
            default: return 3'b010;
        endcase
    endfunction

    // Control word a phase must present; unlisted outputs are 0, ALUOp 00 means add
    function automatic obs_t phase_word(input phase_e ph, input logic rdy,
                                        input logic [5:0] op, input logic [5:0] fn);
        obs_t w;
        w = '0;
        w.alu_control = 3'b010;
        case (ph)
            P_FETCH:    begin w.alu_src_b = 2'b01; w.ir_write = rdy; w.pc_write = rdy; end
            P_DECODE:   begin w.alu_src_b = 2'b11; w.illegal = !is_legal(op, fn); end
            P_MEMADR:   begin w.alu_src_a = 1'b1; w.alu_src_b = 2'b10; end
            P_MEMREAD:  w.iord = 1'b1;
            P_MEMWB:    begin w.memto_reg = 1'b1; w.we3 = 1'b1; w.retire = 1'b1; end
            P_MEMWRITE: begin w.iord = 1'b1; w.mem_write = 1'b1; w.retire = rdy; end
            P_EXEC:     begin w.alu_src_a = 1'b1; w.alu_control = r_alu(fn); end
            P_ALUWB:    begin w.reg_dst = 1'b1; w.we3 = 1'b1; w.retire = 1'b1; end
            P_BRANCH:   begin
                w.alu_src_a = 1'b1; w.alu_control = 3'b110; w.pc_src = 2'b01;
                w.branch = 1'b1; w.retire = 1'b1;
            end
            P_ADDIEXEC: begin w.alu_src_a = 1'b1; w.alu_src_b = 2'b10; end
            P_ADDIWB:   begin w.we3 = 1'b1; w.retire = 1'b1; end
            P_JUMP:     begin w.pc_src = 2'b10; w.pc_write = 1'b1; w.retire = 1'b1; end
            default:    w.alu_src_b = 2'b01;   // reset: FETCH selects, enables off
        endcase
        return w;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input phase_e ph, input logic rdy,
                         input logic [5:0] op, input logic [5:0] fn);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = (ph == P_RESET);
        bus.mem_ready = rdy;
        bus.Op        = op;
        bus.Funct     = fn;
        e.w  = phase_word(ph, rdy, op, fn);
        e.ph = ph;
        expq.push_back(e);
    endtask

    // abort_idx: -1 none, -2 pick randomly, else phase index replaced by reset
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int f_stall, input int m_stall, input int abort_idx);
        phase_e seq[$];
        int     ab;
        bit     aborted;
        seq.push_back(P_FETCH);
        seq.push_back(P_DECODE);
        if (is_legal(op, fn)) begin
            case (op)
                6'd35: begin seq.push_back(P_MEMADR); seq.push_back(P_MEMREAD); seq.push_back(P_MEMWB); end
                6'd43: begin seq.push_back(P_MEMADR); seq.push_back(P_MEMWRITE); end
                6'd0:  begin seq.push_back(P_EXEC); seq.push_back(P_ALUWB); end
                6'd4:  seq.push_back(P_BRANCH);
                6'd8:  begin seq.push_back(P_ADDIEXEC); seq.push_back(P_ADDIWB); end
                default: seq.push_back(P_JUMP);
            endcase
        end
        ab = abort_idx;
        if (ab == -2) begin
            ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, seq.size() - 1)) : -1;
        end
        aborted = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            if (i == ab) begin
                drive(P_RESET, 1'($urandom), op, fn);
                drive(P_RESET, 1'($urandom), op, fn);
                aborted = 1'b1;
                break;
            end
            if (seq[i] == P_FETCH || seq[i] == P_MEMREAD || seq[i] == P_MEMWRITE) begin
                repeat ((seq[i] == P_FETCH) ? f_stall : m_stall) drive(seq[i], 1'b0, op, fn);
                drive(seq[i], 1'b1, op, fn);
            end else begin
                drive(seq[i], 1'($urandom), op, fn);
            end
        end
        if (!aborted) begin
            if (is_legal(op, fn)) retire_exp++;
            else                  illegal_exp++;
        end
    endtask

    function automatic int rnd_stall();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        obs_t obs;
        exp_t e;
        forever begin
            @(negedge clk);
            obs = '{bus.IorD, bus.RegDst, bus.MemtoReg, bus.IRWrite, bus.WE3,
                    bus.ALUSrcA, bus.Branch, bus.PCWrite, bus.ALUSrcB, bus.PCSrc,
                    bus.ALUControl, bus.MemWrite, bus.retire, bus.illegal};
            if (obs.retire === 1'b1)  retire_seen++;
            if (obs.illegal === 1'b1) illegal_seen++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (obs !== e.w) begin
                    errors++;
                    $display("FAIL ctl_word phase=%s t=%0t got=%05h want=%05h",
                             e.ph.name(), $time, obs, e.w);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.Op        = 6'd0;
        bus.Funct     = 6'd32;
        repeat (3) drive(P_RESET, 1'b1, 6'd0, 6'd32);

        // directed cases
        run_instr(6'b100011, 6'($urandom), 0, 0, -1);   // lw, 5 cycles
        run_instr(6'b101011, 6'($urandom), 0, 3, -1);   // sw, 3 stalls in MEMWRITE
        run_instr(6'b000000, 6'b100010,    0, 0, -1);   // sub
        run_instr(6'b000100, 6'($urandom), 0, 0, -1);   // beq
        run_instr(6'b000010, 6'($urandom), 0, 0, -1);   // j
        run_instr(6'b001000, 6'($urandom), 0, 0, -1);   // addi
        run_instr(6'b111111, 6'($urandom), 0, 0, -1);   // illegal opcode
        run_instr(6'b000000, 6'b000001,    0, 0, -1);   // illegal funct
        run_instr(6'b000000, 6'b100000,    0, 0, 2);    // reset in EXECUTE
        run_instr(6'b101011, 6'($urandom), 0, 2, 3);    // reset in MEMWRITE
        run_instr(6'b100011, 6'($urandom), 2, 2, -1);   // lw with both stalls
        run_instr(6'b000000, 6'b101010,    1, 0, -1);   // slt after fetch stall

        // randomized mix
        for (int n = 0; n < 400; n++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2, 3: begin
                    op = 6'b000000;
                    if ($urandom_range(0, 3) != 0) begin
                        case ($urandom_range(0, 4))
                            0: fn = 6'b100000;
                            1: fn = 6'b100010;
                            2: fn = 6'b100100;
                            3: fn = 6'b100101;
                            default: fn = 6'b101010;
                        endcase
                    end
                end
                4: op = 6'b000100;
                5: op = 6'b001000;
                6: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            run_instr(op, fn, rnd_stall(), rnd_stall(), -2);
        end

        @(negedge clk);
        #1;
        checks++;
        if (retire_seen != retire_exp) begin
            errors++;
            $display("FAIL retire_count got=%0d want=%0d", retire_seen, retire_exp);
        end
        checks++;
        if (illegal_seen != illegal_exp) begin
            errors++;
            $display("FAIL illegal_count got=%0d want=%0d", illegal_seen, illegal_exp);
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d want=0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control unit for the multicycle MIPS datapath. It is a Moore state machine that sequences fetch, decode, execute, memory and writeback. Each cycle it drives the datapath's mux selects and write enables, and it drives the external memory write enable. It stalls on a memory-ready handshake and flags unsupported instructions.

## Interface
- No parameters.
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- Op  in  6  instruction[31:26] from the datapath instruction register
- Funct  in  6  instruction[5:0] from the datapath instruction register
- mem_ready  in  1  memory completes the current access this cycle
- IorD, RegDst, MemtoReg, IRWrite, WE3, ALUSrcA, Branch, PCWrite  out  1 each  datapath controls
- ALUSrcB, PCSrc  out  2 each  datapath mux selects
- ALUControl  out  3  ALU operation
- MemWrite  out  1  memory write request
- retire  out  1  one-cycle pulse on the last cycle of each completed instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported Op/Funct

## Operation
- Supported opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010. Any other opcode is illegal.
- Supported R-type funct codes, with their ALUControl: add 100000→010, sub 100010→110, and 100100→000, or 100101→001, slt 101010→111. Any other funct is illegal.
- ALUOp, internal, 2 bits: 00 gives add (010), 01 gives sub (110), 10 decodes Funct.
- All outputs are decoded from the current state. Any output not listed for a state is 0 in that state.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=PCWrite=mem_ready. Hold in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode: lw/sw→MEMADR, R→EXECUTE, beq→BRANCH, addi→ADDIEXEC, j→JUMP. Illegal opcode or funct: illegal=1 and next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: IorD=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, WE3=1, retire=1. Next state FETCH.
- MEMWRITE: IorD=1, MemWrite=1, held high until mem_ready. retire=mem_ready. Go to FETCH on mem_ready.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, WE3=1, retire=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, retire=1. Next state FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, WE3=1, retire=1. Next state FETCH.
- JUMP: PCSrc=10, PCWrite=1, retire=1. Next state FETCH.
- No reachable state is left without a defined exit. An unencoded state value recovers to FETCH on the next edge.

## Timing
- While reset is high: state=FETCH. IRWrite, PCWrite, WE3, MemWrite, Branch, retire and illegal are forced to 0. The mux selects hold their FETCH values.
- Reset asserted mid-instruction aborts the instruction: no WE3 or MemWrite pulse follows it. After release, the first active edge with mem_ready=1 fetches.
- Cycle counts with mem_ready tied high, FETCH included: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No enable pulse is issued during the stall.
- Branch outcome is resolved by the datapath as Zero & Branch. The controller does not observe Zero.
- Exactly one retire pulse per legal instruction. No retire pulse for an illegal instruction.

## Structure
- Package mips_ctrl_pkg holds:
  - state enum typedef: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  - opcode and funct localparams
  - ALUControl encodings and ALUOp encodings
- Sub-module alu_dec: combinational, inputs ALUOp and Funct, outputs ALUControl and funct_illegal.
- The top level holds the state register, next-state logic and output decode.

## Test plan
- Reset with mem_ready=1: during reset IRWrite=PCWrite=0 and state=FETCH. First cycle after release: IRWrite=PCWrite=1, ALUSrcB=01.
- lw (Op 100011) with mem_ready=1: states FETCH→DECODE→MEMADR→MEMREAD→MEMWB. In MEMWB, WE3=1, MemtoReg=1, RegDst=0, retire=1. Total 5 cycles.
- sw (Op 101011) with mem_ready held low for 3 cycles in MEMWRITE: MemWrite=1 for 4 cycles, retire pulses once in the 4th, then the controller returns to FETCH.
- R-type sub (Funct 100010): EXECUTE drives ALUControl=110, ALUWB drives RegDst=1 and WE3=1. beq: BRANCH drives ALUControl=110, Branch=1, PCSrc=01.
- j (Op 000010): JUMP drives PCSrc=10 and PCWrite=1 and takes 3 cycles. addi: ADDIWB drives RegDst=0 and WE3=1.
- Illegal input, Op 111111 or R-type Funct 000001: illegal=1 in DECODE, no WE3/MemWrite/retire, back to FETCH next cycle. Reset asserted in EXECUTE: no ALUWB write.
